// File: rtl/m_ext_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness decode.
package m_ext_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StWb   = 2'd3
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/m_ext_unit_sign_fix.sv
// Combinational conditional two's-complement negation of a WIDTH-bit value.
module sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/m_ext_unit.sv
// Iterative RV32M unit: XLEN-cycle shift-add multiply / restoring divide on operand
// magnitudes, sign fix-up in FIX, one-cycle register-file write-back in WB.
module m_ext_unit
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int unsigned CntW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opa_q;      // raw dividend, returned as remainder on divide-by-zero
    logic [XLEN-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;      // mul: {hi, multiplier/lo}; div: {remainder, quotient}
    logic              neg_q;
    logic              sa_q;
    logic              dz_q;
    logic              ovf_q;
    logic              done_q;
    logic              we_q;
    logic [4:0]        waddr_q;
    logic [XLEN-1:0]   wdata_q;

    // Accept-time operand decode
    logic            a_neg, b_neg, is_mul;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_mul = ~funct3[2];
        a_neg  = op_a_signed(funct3) & rs1_val[XLEN-1];
        b_neg  = op_b_signed(funct3) & rs2_val[XLEN-1];
        a_mag  = a_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
        b_mag  = b_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
    end

    // One iteration of each algorithm
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : XLEN'(0))};
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        // Borrow out of the trial subtraction means the divisor did not fit: restore.
        if (div_diff[XLEN]) begin
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
        .value  (acc_q),
        .negate (neg_q),
        .result (prod_s)
    );

    sign_fix #(.WIDTH(XLEN)) u_fix_quo (
        .value  (acc_q[XLEN-1:0]),
        .negate (neg_q),
        .result (quo_s)
    );

    sign_fix #(.WIDTH(XLEN)) u_fix_rem (
        .value  (acc_q[2*XLEN-1:XLEN]),
        .negate (sa_q),
        .result (rem_s)
    );

    logic [XLEN-1:0] result;

    always_comb begin
        result = '0;
        if (!f3_q[2]) begin
            result = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (!f3_q[1]) begin
            if (dz_q) begin
                result = '1;
            end else if (ovf_q) begin
                result = {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                result = quo_s;
            end
        end else begin
            if (dz_q) begin
                result = opa_q;
            end else if (ovf_q) begin
                result = '0;
            end else begin
                result = rem_s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCalc;
            StCalc: if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
            StFix:  state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        f3_q  <= funct3;
                        rd_q  <= rd_addr;
                        opa_q <= rs1_val;
                        opb_q <= is_mul ? a_mag : b_mag;
                        acc_q <= {XLEN'(0), (is_mul ? b_mag : a_mag)};
                        neg_q <= a_neg ^ b_neg;
                        sa_q  <= a_neg;
                        dz_q  <= ~is_mul && (rs2_val == '0);
                        ovf_q <= ~is_mul && ~funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                                 && (rs2_val == '1);
                        cnt_q <= '0;
                    end
                end
                StCalc: begin
                    acc_q <= f3_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                end
                StFix: begin
                    done_q  <= 1'b1;
                    we_q    <= (rd_q != 5'd0);
                    waddr_q <= rd_q;
                    wdata_q <= result;
                end
                StWb: ;
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign wb_we   = we_q;
    assign wb_addr = waddr_q;
    assign wb_data = wdata_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit: vector table of single operations plus
// hand-written sequences for start-while-busy and mid-calculation reset.
module tb_m_ext_unit;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_addr;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    m_ext_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .start      (start),
        .funct3     (funct3),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        exp_we;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input logic exp_we);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.exp_we = exp_we;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for done; returns number of edges after the accept edge.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input vec_t v);
        int n;
        @(negedge clk);
        funct3 = v.f3; rs1_val = v.a; rs2_val = v.b; rd_addr = v.rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs1_val = ~v.a; rs2_val = v.b + 32'd5; rd_addr = ~v.rd; funct3 = ~v.f3;
        check({v.name, " busy@accept"}, 32'(busy), 32'd1);
        wait_done(n);
        check({v.name, " latency"}, 32'(n), 32'd33);
        check({v.name, " wb_data"}, wb_data, v.exp);
        check({v.name, " wb_addr"}, 32'(wb_addr), 32'(v.rd));
        check({v.name, " wb_we"}, 32'(wb_we), 32'(v.exp_we));
        check({v.name, " busy@wb"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({v.name, " idle after"}, {29'd0, busy, done, wb_we}, 32'd0);
    endtask

    initial begin
        int   n;
        logic seen_we;
        vec_t v;

        sync_reset = 1'b1; start = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", {29'd0, busy, done, wb_we}, 32'd0);
        check("reset wb_addr", 32'(wb_addr), 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        @(negedge clk);
        sync_reset = 1'b0;

        add("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b1);
        add("MULH ovf",      3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h00000000, 1'b1);
        add("MULHSU ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 1'b1);
        add("MULHU ovf",     3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h7FFFFFFF, 1'b1);
        add("MULH 7*-3",     3'b001, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFFF, 1'b1);
        add("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 1'b1);
        add("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 1'b1);
        add("DIV -7/-2",     3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd12, 32'd3,        1'b1);
        add("REM 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        1'b1);
        add("DIVU 100/7",    3'b101, 32'd100,      32'd7,        5'd14, 32'd14,       1'b1);
        add("REMU 100/7",    3'b111, 32'd100,      32'd7,        5'd15, 32'd2,        1'b1);
        add("DIVU /0",       3'b101, 32'h12345678, 32'd0,        5'd16, 32'hFFFFFFFF, 1'b1);
        add("DIV /0",        3'b100, 32'h12345678, 32'd0,        5'd17, 32'hFFFFFFFF, 1'b1);
        add("REM /0",        3'b110, 32'h12345678, 32'd0,        5'd18, 32'h12345678, 1'b1);
        add("REMU /0",       3'b111, 32'h12345678, 32'd0,        5'd19, 32'h12345678, 1'b1);
        add("REM neg /0",    3'b110, 32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFF9, 1'b1);
        add("DIV overflow",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1'b1);
        add("REM overflow",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h00000000, 1'b1);
        add("MUL rd0",       3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       1'b0);

        foreach (vecs[i]) do_op(vecs[i]);

        // start held high through busy: second accept only once back in IDLE
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd5; rs2_val = 32'd6; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        rs1_val = 32'd9; rs2_val = 32'd9; rd_addr = 5'd4;
        wait_done(n);
        check("hold first latency", 32'(n), 32'd33);
        check("hold first data", wb_data, 32'd30);
        check("hold first addr", 32'(wb_addr), 32'd3);
        @(posedge clk); #1;
        check("hold idle gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold re-accept", 32'(busy), 32'd1);
        wait_done(n);
        check("hold second latency", 32'(n), 32'd33);
        check("hold second data", wb_data, 32'd81);
        check("hold second addr", 32'(wb_addr), 32'd4);
        @(posedge clk); #1;

        // reset mid-calculation discards the operation
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd3; rd_addr = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sync_reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid busy", 32'(busy), 32'd0);
        check("reset mid done/we", {30'd0, done, wb_we}, 32'd0);
        @(negedge clk);
        sync_reset = 1'b0;
        seen_we = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (wb_we === 1'b1 || done === 1'b1 || busy === 1'b1) seen_we = 1'b1;
        end
        check("reset no writeback", 32'(seen_we), 32'd0);

        v.name = "MUL 2*3 post-reset"; v.f3 = 3'b000; v.a = 32'd2; v.b = 32'd3;
        v.rd = 5'd4; v.exp = 32'd6; v.exp_we = 1'b1;
        do_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
